// File: rtl/rr_arbiter_four_if.sv
// Handshake bundle between the four requesters and the round-robin arbiter:
// request lines, per-requester data bits, and the registered grant/select
// outputs with the shared data output.
interface rr_arbiter_four_if;
    logic [3:0] req;
    logic       w3;
    logic       w2;
    logic       w1;
    logic       w0;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       y;

    // Requester side: drives requests and data, observes the grant.
    modport master (
        output req, w3, w2, w1, w0,
        input  gnt, s1, s0, busy, y
    );

    // Arbiter side.
    modport slave (
        input  req, w3, w2, w1, w0,
        output gnt, s1, s0, busy, y
    );
endinterface

// File: rtl/rr_arbiter_four.sv
// Four-way round-robin arbiter with a bounded hold time per owner and a
// mandatory one-cycle gap between consecutive grants. The last owner's
// select is kept after release so the shared data mux stays stable.
module rr_arbiter_four #(
    parameter int MAX_HOLD = 8  // legal range 1..255
) (
    input logic              clk,
    input logic              rst_n,
    rr_arbiter_four_if.slave bus
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    // Last hold_cnt value of a grant: the owner is released at the edge
    // where the counter sits here, giving exactly MAX_HOLD grant cycles.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_n;
    logic [3:0] gnt_q,   gnt_n;
    logic [1:0] sel_q,   sel_n;
    logic       busy_q,  busy_n;
    logic [1:0] ptr_q,   ptr_n;
    logic [7:0] hold_q,  hold_n;

    logic [1:0] winner;
    logic       any_req;
    logic       owner_req;
    logic       hold_done;
    logic [3:0] w_vec;

    assign any_req   = |bus.req;
    assign owner_req = bus.req[sel_q];
    assign hold_done = (hold_q == HOLD_LAST);
    assign w_vec     = {bus.w3, bus.w2, bus.w1, bus.w0};

    // Round-robin pick: scan from ptr downwards in priority so the
    // requester closest to ptr (mod 4) is the last assignment and wins.
    always_comb begin
        winner = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr_q + 2'(k)]) begin
                winner = ptr_q + 2'(k);
            end
        end
    end

    // Next-state and next-output decode for the IDLE/GRANT/GAP controller.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_n = state_q;
        gnt_n   = gnt_q;
        sel_n   = sel_q;
        busy_n  = busy_q;
        ptr_n   = ptr_q;
        hold_n  = hold_q;

        unique case (state_q)
            IDLE, GAP: begin
                // Non-owner requests are only looked at here, on an
                // arbitration edge; GAP uses the ptr updated on release.
                if (any_req) begin
                    state_n = GRANT;
                    gnt_n   = 4'b0001 << winner;
                    sel_n   = winner;
                    busy_n  = 1'b1;
                    hold_n  = 8'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                // Owner drop and hold expiry on the same edge are one exit.
                if (!owner_req || hold_done) begin
                    state_n = GAP;
                    gnt_n   = 4'b0000;
                    busy_n  = 1'b0;
                    ptr_n   = sel_q + 2'd1;
                end else if (hold_q != 8'hFF) begin
                    hold_n = hold_q + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            ptr_q   <= 2'd0;
            hold_q  <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_n;
            gnt_q   <= gnt_n;
            sel_q   <= sel_n;
            busy_q  <= busy_n;
            ptr_q   <= ptr_n;
            hold_q  <= hold_n;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.s1   = sel_q[1];
    assign bus.s0   = sel_q[0];
    assign bus.busy = busy_q;
    // Shared data out: muxed by the registered select, gated by busy so it
    // reads 0 in every gap and idle cycle.
    assign bus.y    = w_vec[sel_q] & busy_q;

endmodule

// File: doc/rr_arbiter_four.md
RR_ARBITER_FOUR -- requirements
Module: rr_arbiter_four

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles per owner; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req  input  4  request lines; req[i] belongs to requester i.
REQ-005 w3, w2, w1, w0  input  1 each  requester data bits; wi belongs to requester i.
REQ-006 gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-007 s1, s0  output  1 each  registered select; {s1,s0} = index of the current or last owner.
REQ-008 busy  output  1  registered; 1 iff gnt != 0.
REQ-009 y  output  1  shared data out; y = w[{s1,s0}] AND busy (combinational from registered select).

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT, GAP.
REQ-011 IDLE: gnt=0; if req != 0 at a clock edge, go to GRANT with the arbitration winner granted at that edge; else stay in IDLE.
REQ-012 Arbitration: round-robin; priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the winner is the first index with req set.
REQ-013 ptr: 2-bit register; on leaving GRANT, ptr <= owner+1 mod 4 (3 wraps to 0); unchanged otherwise.
REQ-014 On entering GRANT: gnt <= one-hot(winner), {s1,s0} <= winner, busy <= 1, hold_cnt <= 0.
REQ-015 GRANT: hold_cnt increments by 1 per cycle while in GRANT; hold_cnt is 8 bits wide and never wraps.
REQ-016 GRANT exit: at an edge where req[owner]==0 OR hold_cnt==MAX_HOLD-1, go to GAP; gnt <= 0; busy <= 0; {s1,s0} holds.
REQ-017 A grant SHALL therefore last 1..MAX_HOLD cycles; MAX_HOLD=1 gives exactly one grant cycle per owner.
REQ-018 Break-before-make: between two grants, gnt SHALL be 0 for at least one cycle (GAP).
REQ-019 GAP: lasts exactly one cycle; if req != 0, go to GRANT (arbitrating with the updated ptr); else go to IDLE.
REQ-020 Changes in non-owner req bits during GRANT SHALL be ignored; they are sampled only at an arbitration edge.
REQ-021 Simultaneous owner drop and hold expiry: treat as one exit; ptr advances once.
REQ-022 An owner whose req stays high after a forced release re-competes normally and gets lowest priority at the next arbitration.
REQ-023 Latency: req asserted in IDLE before an edge -> gnt at that edge (1 cycle); worst-case wait for a continuously requesting input = 3*(MAX_HOLD+1) cycles.
REQ-024 gnt SHALL never have more than one bit set.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force: state=IDLE, gnt=0000, {s1,s0}=00, busy=0, ptr=0, hold_cnt=0; hence y=0.
REQ-026 Reset asserted mid-GRANT SHALL drop the grant at once, with no GAP cycle; the first arbitration after release starts from ptr=0.
REQ-027 After rst_n deasserts, the first arbitration SHALL occur at the first rising clk edge at which rst_n is high.

Verification
REQ-028 Reset, then req=1111 held, MAX_HOLD=8 -> gnt sequence 0001(8 cycles), 0000(1), 0010(8), 0000, 0100(8), 0000, 1000(8), 0000, 0001 ...
REQ-029 req=0100 for 3 cycles, then 0000; w2=1 -> gnt=0100 and y=1 for 3 cycles, one GAP cycle, then IDLE with gnt=0000, busy=0, y=0, {s1,s0}=10 held.
REQ-030 Owner 1 granted; req[3] rises mid-grant; req[1] drops at cycle 2 -> GAP, then gnt=1000, ptr=2 before that arbitration.
REQ-031 MAX_HOLD=1, req=1010 held -> gnt alternates 0010,0000,1000,0000,0010; never two consecutive grant cycles.
REQ-032 rst_n pulled low mid-grant, between edges, with gnt=0100 -> gnt=0000, busy=0, y=0 before the next edge; after release, req=1111 -> gnt=0001.
REQ-033 Data path: grant requester 3 with w3 toggling, other w bits = 1 -> y tracks w3 exactly; y=0 in every GAP cycle.
